// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_pkg
//  Purpose  : Shared constants, overlap-mode encoding and the progress-width
//             helper for the parameterised serial sequence detector.
//  Revision : 1.0  initial release
// ============================================================================
package seq_detect_pkg;

    // Longest pattern the detector is expected to handle
    localparam int LEN_MAX = 16;

    // Encoding of the ovl_mode input
    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    // Bits needed to hold progress values 0..len inclusive
    function automatic int prog_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : seq_sat_counter
//  Purpose  : Up counter that sticks at its all-ones value instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module seq_sat_counter
    import seq_detect_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;

    // Count increment requests, holding once the maximum value is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_param
//  Purpose  : Moore serial pattern detector with a loadable LEN-bit pattern,
//             selectable overlapping / non-overlapping detection and an
//             optional saturating match counter.
//             Build option: define SEQ_DETECT_COUNT_EN to build the match
//             counter; otherwise match_cnt is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter int             CNT_W   = 8,
    parameter logic [LEN-1:0] PAT_RST = 4'b1101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             ovl_mode,
    input  logic             pat_load,
    input  logic [LEN-1:0]   pat_in,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               c_PW    = prog_width(LEN);
    localparam logic [c_PW-1:0]  c_MATCH = c_PW'(LEN);

    logic [LEN-1:0]  r_pat;    // pattern, bit LEN-1 is the first bit expected
    logic [c_PW-1:0] r_prog;   // number of pattern bits matched so far
    logic            r_z;

    logic [c_PW-1:0] w_peff;   // progress the incoming bit is appended to
    logic [c_PW-1:0] w_next;

    // Next progress after appending bit xb to the first peff pattern bits:
    // the longest pattern prefix that is a suffix of that history. A plain
    // advance is simply the case k = peff+1, so one search covers both the
    // matching and the failure-function transitions for any pattern.
    function automatic logic [c_PW-1:0] next_prog(
        input logic [LEN-1:0]  pat,
        input logic [c_PW-1:0] peff,
        input logic            xb
    );
        logic [LEN-1:0]  rev;   // rev[j] = j-th bit of the pattern in arrival order
        logic [LEN:0]    hist;  // hist[t] = t-th bit of the recent history
        logic [c_PW-1:0] best;
        logic            ok;
        int              base;

        for (int j = 0; j < LEN; j++) begin
            rev[j] = pat[LEN-1-j];
        end

        hist = '0;
        for (int t = 0; t < LEN; t++) begin
            if (t < int'(peff)) begin
                hist[t] = rev[t];
            end
        end
        hist[peff] = xb;

        best = '0;
        for (int k = 1; k <= LEN_MAX; k++) begin
            if ((k <= LEN) && (k <= int'(peff) + 1)) begin
                ok   = 1'b1;
                base = int'(peff) + 1 - k;
                for (int i = 0; i < LEN; i++) begin
                    if ((i < k) && (rev[i] != hist[c_PW'(base + i)])) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = c_PW'(k);
                end
            end
        end
        return best;
    endfunction

    // Leaving MATCH either keeps the whole match as history (overlap) or starts afresh
    always_comb begin
        w_peff = r_prog;
        if (r_prog == c_MATCH) begin
            case (ovl_mode)
                OVL_ON:  w_peff = r_prog;
                OVL_OFF: w_peff = '0;
                default: w_peff = '0;
            endcase
        end
    end

    assign w_next = next_prog(r_pat, w_peff, x);

    // Detector state: reset beats pattern load, which beats bit consumption
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat  <= PAT_RST;
            r_prog <= '0;
            r_z    <= 1'b0;
        end else if (pat_load) begin
            r_pat  <= pat_in;
            r_prog <= '0;
            r_z    <= 1'b0;
        end else if (x_valid) begin
            r_prog <= w_next;
            r_z    <= (w_next == c_MATCH);
        end
    end

    assign z = r_z;

`ifdef SEQ_DETECT_COUNT_EN
    logic w_inc;

    // One count per consumed bit that lands in MATCH
    assign w_inc = ~rst & ~pat_load & x_valid & (w_next == c_MATCH);

    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_inc),
        .cnt (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detect_param
//  Purpose  : Directed table-driven bench for seq_detect_param (LEN=4, 1101),
//             plus hand-written saturation / reset-in-MATCH sequences using
//             a second instance with CNT_W=2.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_detect_param;

`ifdef SEQ_DETECT_COUNT_EN
    localparam bit c_CNT_ON = 1'b1;
`else
    localparam bit c_CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       x;
    logic       x_valid;
    logic       ovl_mode;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       z;
    logic [7:0] match_cnt;
    logic       z_s;
    logic [1:0] match_cnt_s;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       rst;
        logic       xv;
        logic       x;
        logic       ovl;
        logic       ld;
        logic [3:0] pin;
        logic       ez;
        int         ecnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .x_valid   (x_valid),
        .ovl_mode  (ovl_mode),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .z         (z),
        .match_cnt (match_cnt)
    );

    seq_detect_param #(
        .CNT_W (2)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .x_valid   (x_valid),
        .ovl_mode  (ovl_mode),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .z         (z_s),
        .match_cnt (match_cnt_s)
    );

    // Expected counter value for a given number of matches and counter maximum
    function automatic int cexp(input int v, input int maxv);
        if (!c_CNT_ON) return 0;
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Present one cycle of inputs and return just after the consuming edge
    task automatic drive(input logic r, input logic xv, input logic xb, input logic ov,
                         input logic ld, input logic [3:0] pi);
        @(negedge clk);
        rst = r; x_valid = xv; x = xb; ovl_mode = ov; pat_load = ld; pat_in = pi;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic xv, input logic xb, input logic ov,
                       input logic ld, input logic [3:0] pi, input logic ez, input int ec);
        vec_t v;
        v.rst = r; v.xv = xv; v.x = xb; v.ovl = ov; v.ld = ld; v.pin = pi;
        v.ez = ez; v.ecnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] sat_stream;
        int          m;
        logic        ez;

        rst = 1'b1; x = 1'b0; x_valid = 1'b0; ovl_mode = 1'b1; pat_load = 1'b0; pat_in = 4'b0;

        // Overlapping, stream 1101101: matches after bits 4 and 7
        add(1,0,0,1,0,4'h0, 0,0);
        add(0,1,1,1,0,4'h0, 0,0); add(0,1,1,1,0,4'h0, 0,0); add(0,1,0,1,0,4'h0, 0,0);
        add(0,1,1,1,0,4'h0, 1,1); add(0,1,1,1,0,4'h0, 0,1); add(0,1,0,1,0,4'h0, 0,1);
        add(0,1,1,1,0,4'h0, 1,2);
        // Non-overlapping, same stream: single match
        add(1,0,0,0,0,4'h0, 0,0);
        add(0,1,1,0,0,4'h0, 0,0); add(0,1,1,0,0,4'h0, 0,0); add(0,1,0,0,0,4'h0, 0,0);
        add(0,1,1,0,0,4'h0, 1,1); add(0,1,1,0,0,4'h0, 0,1); add(0,1,0,0,0,4'h0, 0,1);
        add(0,1,1,0,0,4'h0, 0,1);
        // Stream 11101: progress holds at 2 on repeated 1
        add(1,0,0,1,0,4'h0, 0,0);
        add(0,1,1,1,0,4'h0, 0,0); add(0,1,1,1,0,4'h0, 0,0); add(0,1,1,1,0,4'h0, 0,0);
        add(0,1,0,1,0,4'h0, 0,0); add(0,1,1,1,0,4'h0, 1,1);
        // 1101 with 3-cycle invalid gaps carrying the opposite bit
        add(1,0,0,1,0,4'h0, 0,0);
        add(0,1,1,1,0,4'h0, 0,0);
        add(0,0,0,1,0,4'h0, 0,0); add(0,0,0,1,0,4'h0, 0,0); add(0,0,0,1,0,4'h0, 0,0);
        add(0,1,1,1,0,4'h0, 0,0);
        add(0,0,0,1,0,4'h0, 0,0); add(0,0,0,1,0,4'h0, 0,0); add(0,0,0,1,0,4'h0, 0,0);
        add(0,1,0,1,0,4'h0, 0,0);
        add(0,0,1,1,0,4'h0, 0,0); add(0,0,1,1,0,4'h0, 0,0); add(0,0,1,1,0,4'h0, 0,0);
        add(0,1,1,1,0,4'h0, 1,1);
        add(0,0,0,1,0,4'h0, 1,1); add(0,0,0,1,0,4'h0, 1,1); add(0,0,0,1,0,4'h0, 1,1);
        add(0,1,0,1,0,4'h0, 0,1);
        // Pattern load while P=3: bit on load edge discarded, count kept
        add(1,0,0,1,0,4'h0, 0,0);
        add(0,1,1,1,0,4'h0, 0,0); add(0,1,1,1,0,4'h0, 0,0); add(0,1,0,1,0,4'h0, 0,0);
        add(0,1,1,1,0,4'h0, 1,1); add(0,1,1,1,0,4'h0, 0,1); add(0,1,0,1,0,4'h0, 0,1);
        add(0,1,0,1,1,4'b0110, 0,1);
        add(0,1,1,1,0,4'h0, 0,1); add(0,1,1,1,0,4'h0, 0,1); add(0,1,0,1,0,4'h0, 0,1);
        add(0,1,1,1,0,4'h0, 0,1); add(0,1,1,1,0,4'h0, 0,1); add(0,1,0,1,0,4'h0, 1,2);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].xv, vecs[i].x, vecs[i].ovl, vecs[i].ld, vecs[i].pin);
            check($sformatf("vec%0d z", i), {31'd0, z}, {31'd0, vecs[i].ez});
            check($sformatf("vec%0d match_cnt", i), {24'd0, match_cnt}, cexp(vecs[i].ecnt, 255));
        end

        // Five overlapping matches: CNT_W=2 instance saturates at 3
        drive(1,0,0,1,0,4'h0);
        sat_stream = 16'b1101101101101101;
        m = 0;
        for (int i = 0; i < 16; i++) begin
            drive(0,1,sat_stream[15-i],1,0,4'h0);
            ez = ((i + 1) >= 4) && (((i + 1 - 4) % 3) == 0);
            if (ez) m++;
            check($sformatf("sat bit%0d z", i + 1), {31'd0, z_s}, {31'd0, ez});
            check($sformatf("sat bit%0d cnt2", i + 1), {30'd0, match_cnt_s}, cexp(m, 3));
        end
        check("sat full-width cnt", {24'd0, match_cnt}, cexp(5, 255));

        // Reset in MATCH beats a simultaneous load and valid bit
        drive(1,1,1,1,1,4'b0000);
        check("rst in match z", {31'd0, z}, 32'd0);
        check("rst in match cnt", {24'd0, match_cnt}, 32'd0);
        check("rst in match cnt2", {30'd0, match_cnt_s}, 32'd0);

        // Pattern register back to 1101 after reset
        drive(0,1,1,1,0,4'h0);
        drive(0,1,1,1,0,4'h0);
        drive(0,1,0,1,0,4'h0);
        check("post-rst bit3 z", {31'd0, z}, 32'd0);
        drive(0,1,1,1,0,4'h0);
        check("post-rst pattern z", {31'd0, z}, 32'd1);
        check("post-rst pattern cnt", {24'd0, match_cnt}, cexp(1, 255));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter LEN, default 4, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have parameter PAT_RST, default 4'b1101 (LEN bits), the pattern loaded at reset.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 x  input  1  serial data bit.
REQ-007 x_valid  input  1  x is consumed on a rising edge only when x_valid=1.
REQ-008 ovl_mode  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 pat_load  input  1  load pat_in into the pattern register.
REQ-010 pat_in  input  LEN  new pattern; bit LEN-1 is the first bit received.
REQ-011 z  output  1  Moore match flag.
REQ-012 match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-013 SHALL hold state as progress P in 0..LEN, equal to the number of pattern bits matched so far; P=LEN is the MATCH state.
REQ-014 z SHALL be 1 exactly when P=LEN, decoded from state only, with no combinational path from x.
REQ-015 When x_valid=0 and pat_load=0, P, z and match_cnt SHALL hold.
REQ-016 When P<LEN and x equals the next pattern bit, P SHALL advance to P+1.
REQ-017 When P<LEN and x mismatches, P SHALL become the length of the longest proper prefix of the pattern that is a suffix of the received bits (failure function). Example for 1101: in P=2 with x=1, P stays 2.
REQ-018 In MATCH with ovl_mode=1, the next bit SHALL continue from the failure value of the full pattern. For 1101 that value is 1.
REQ-019 In MATCH with ovl_mode=0, the next bit SHALL be treated as the start of a new search: P becomes 1 if x equals the first pattern bit, otherwise 0.
REQ-020 ovl_mode SHALL be sampled on the same edge that consumes the bit leaving MATCH.
REQ-021 The failure function SHALL be derived combinationally from the pattern register for any legal LEN; hard-coded tables are not allowed.
REQ-022 Latency: z SHALL rise on the clock edge that consumes the final pattern bit and SHALL be visible in the following cycle.
REQ-023 pat_load=1 SHALL capture pat_in and force P=0 on the same edge. It takes priority over x_valid, and the bit presented on that edge is discarded.
REQ-024 match_cnt SHALL increment by 1 on each entry into MATCH and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-025 pat_load SHALL NOT clear match_cnt.

Reset
REQ-026 rst=1 SHALL set P=0, z=0, match_cnt=0 and pattern register=PAT_RST on the next rising edge.
REQ-027 rst SHALL take priority over pat_load and x_valid, including when asserted mid-sequence or in MATCH.

Configuration
REQ-028 Macro SEQ_DETECT_COUNT_EN SHALL control the match counter.
- Defined: the counter is implemented per REQ-024.
- Undefined: no counter logic is built and match_cnt is tied to 0.
- All other behaviour is identical in both builds.

Structure
REQ-029 A shared package seq_detect_pkg SHALL hold:
- the LEN_MAX=16 constant;
- the progress-width function clog2(LEN+1);
- the overlap-mode encoding constants OVL_ON and OVL_OFF.
REQ-030 The saturating counter SHALL be a sub-module seq_sat_counter with parameter CNT_W and ports clk, rst, inc, cnt.
REQ-031 The FSM and the failure-function logic SHALL reside in seq_detect_param.

Verification
REQ-032 LEN=4, pattern 1101, ovl_mode=1, stream 1101101 with x_valid=1 throughout -> z high after bit 4 and after bit 7; match_cnt=2.
REQ-033 Same stream with ovl_mode=0 -> z high after bit 4 only; match_cnt=1.
REQ-034 Stream 1 1 1 0 1 -> z stays 0 through bit 4 and goes high after bit 5, confirming that P holds at 2 on a repeated 1.
REQ-035 Stream 1101 with x_valid=0 gaps of 3 cycles between bits -> z rises only after the 4th valid bit and stays high until the next valid bit.
REQ-036 pat_load with pat_in=4'b0110 issued while P=3 -> P=0 and the bit on that edge is ignored; the following stream 0110 -> z high, and match_cnt is unchanged by the load itself.
REQ-037 Saturation and reset:
- CNT_W=2, 5 consecutive overlapping matches -> match_cnt stops at 3.
- rst asserted in MATCH -> z=0 and match_cnt=0 on the next edge.
- Build without SEQ_DETECT_COUNT_EN -> match_cnt stays 0 throughout.
